pwm_duty_slew: RTL and testbench

- Sits between the SPI register bank and the PWM peripheral.
- Takes the raw duty-cycle byte written over SPI (target) and drives the PWM duty input (duty_out).
- Moves duty_out toward the target in fixed steps at a programmable rate, so outputs ramp instead of jumping.
- Pure synchronous block on the system clock; no SPI or PWM logic inside.

---
 rtl/pwm_duty_slew.sv | 71 +++++++
 tb/tb_pwm_duty_slew.sv | 132 +++++++++++++
 2 files changed

// File: rtl/pwm_duty_slew.sv
// pwm_duty_slew: ramps duty_out toward target_duty in step-sized increments every tick_div+1 clocks
module pwm_duty_slew #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] target_duty,
  input  logic [WIDTH-1:0] step,
  input  logic [DIV_W-1:0] tick_div,
  output logic [WIDTH-1:0] duty_out,
  output logic             busy,
  output logic             at_target
);
  typedef enum logic {IDLE, RAMP} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic at_target_q, at_target_d;
  logic signed [WIDTH:0] diff, step_s;
  logic tick;
  assign diff = $signed({1'b0, target_duty}) - $signed({1'b0, duty_q});
  assign step_s = $signed({1'b0, step});
  assign tick = presc_q == tick_div;
  always_comb begin
    state_d = state_q;
    duty_d = duty_q;
    presc_d = presc_q;
    at_target_d = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      duty_d = '0;
      presc_d = '0;
    end else if (step == '0) begin
      state_d = IDLE;
      duty_d = target_duty;
      presc_d = '0;
    end else if (state_q == IDLE) begin
      state_d = target_duty != duty_q ? RAMP : IDLE;
      presc_d = '0;
    end else begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        if (diff <= step_s && diff >= -step_s) begin
          duty_d = target_duty;
          state_d = IDLE;
          at_target_d = 1'b1;
        end else begin
          duty_d = diff > step_s ? duty_q + step : duty_q - step;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      duty_q <= '0;
      presc_q <= '0;
      at_target_q <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q <= duty_d;
      presc_q <= presc_d;
      at_target_q <= at_target_d;
    end
  end
  assign duty_out = duty_q;
  assign busy = state_q == RAMP;
  assign at_target = at_target_q;
endmodule

// File: tb/tb_pwm_duty_slew.sv
// tb_pwm_duty_slew: directed and random stimulus checked against a cycle-level arithmetic model
module tb_pwm_duty_slew;
  logic clk = 1'b0;
  logic rst, enable, busy, at_target;
  logic [7:0] target_duty, step, duty_out;
  logic [15:0] tick_div;
  int total = 0, bad = 0;
  int md = 0, mp = 0;
  bit mramp = 0, mat = 0;

  always #5 clk = ~clk;

  pwm_duty_slew dut (
    .clk(clk), .rst(rst), .enable(enable), .target_duty(target_duty), .step(step),
    .tick_div(tick_div), .duty_out(duty_out), .busy(busy), .at_target(at_target)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model();
    int t, s, d;
    t = int'(target_duty);
    s = int'(step);
    mat = 0;
    if (rst || !enable) begin
      md = 0; mramp = 0; mp = 0;
    end else if (s == 0) begin
      md = t; mramp = 0; mp = 0;
    end else if (!mramp) begin
      mramp = (t != md);
      mp = 0;
    end else if (mp == int'(tick_div)) begin
      mp = 0;
      d = t - md;
      if ((d < 0 ? -d : d) <= s) begin
        md = t; mramp = 0; mat = 1;
      end else md = d > 0 ? md + s : md - s;
    end else mp = (mp + 1) % 65536;
  endtask

  task automatic cyc();
    @(posedge clk);
    model();
    #1;
    chk("duty", 32'(duty_out), 32'(md));
    chk("busy", 32'(busy), 32'(mramp));
    chk("at_target", 32'(at_target), 32'(mat));
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  initial begin
    rst = 1; enable = 1; target_duty = 0; step = 0; tick_div = 0;
    run(2);
    chk("reset_duty", 32'(duty_out), 0);
    chk("reset_busy", 32'(busy), 0);
    rst = 0;
    step = 50; tick_div = 3; target_duty = 200;
    cyc();
    chk("up_busy_rise", 32'(busy), 1);
    run(4);
    chk("up_50", 32'(duty_out), 50);
    run(4);
    chk("up_100", 32'(duty_out), 100);
    run(8);
    chk("up_200", 32'(duty_out), 200);
    chk("up_at", 32'(at_target), 1);
    chk("up_busy_fall", 32'(busy), 0);
    cyc();
    chk("up_at_once", 32'(at_target), 0);
    rst = 1; cyc(); rst = 0;
    target_duty = 0; cyc();
    target_duty = 200; run(6);
    rst = 1; cyc();
    chk("rst_mid_duty", 32'(duty_out), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    run(3);
    chk("rst_hold_busy", 32'(busy), 0);
    rst = 0;
    step = 60; tick_div = 0; target_duty = 130;
    run(2);
    chk("clamp_60", 32'(duty_out), 60);
    cyc();
    chk("clamp_120", 32'(duty_out), 120);
    cyc();
    chk("clamp_130", 32'(duty_out), 130);
    chk("clamp_at", 32'(at_target), 1);
    step = 0; target_duty = 255; cyc();
    step = 16; tick_div = 1; target_duty = 0;
    run(5);
    chk("down_223", 32'(duty_out), 223);
    target_duty = 240;
    run(2);
    chk("retarget_239", 32'(duty_out), 239);
    run(2);
    chk("retarget_240", 32'(duty_out), 240);
    chk("retarget_at", 32'(at_target), 1);
    step = 0; target_duty = 8'h5A; cyc();
    chk("bypass", 32'(duty_out), 32'h5A);
    chk("bypass_at", 32'(at_target), 0);
    enable = 0; cyc();
    chk("disable", 32'(duty_out), 0);
    enable = 1; step = 8; tick_div = 0; run(2);
    chk("reenable_8", 32'(duty_out), 8);
    repeat (3000) begin
      if ($urandom_range(0, 15) == 0) target_duty = 8'($urandom);
      if ($urandom_range(0, 31) == 0) step = $urandom_range(0, 3) == 0 ? 8'd0 : 8'($urandom_range(1, 80));
      if ($urandom_range(0, 31) == 0) tick_div = 16'($urandom_range(0, 5));
      enable = $urandom_range(0, 99) != 0;
      rst = $urandom_range(0, 199) == 0;
      cyc();
    end
    rst = 1; enable = 1; step = 1; tick_div = 16'hFFFF; target_duty = 0; cyc();
    rst = 0; target_duty = 1; cyc();
    chk("long_entry", 32'(busy), 1);
    run(65535);
    chk("long_before", 32'(duty_out), 0);
    cyc();
    chk("long_tick", 32'(duty_out), 1);
    chk("long_at", 32'(at_target), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
